// File: rtl/fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg : shared types and constants for the instruction fetch slice
// Revision  : 1.0
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  function automatic logic is_hlt(input logic [15:0] word);
    return word[15:12] == OPC_HLT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_queue : in-order FIFO holding fetched {instr, pc} entries
// Revision    : 1.0
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign full   = (r_count == (c_PTR_W+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage is cleared on reset so the head reads 0 while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= push_data;
        r_wptr        <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_fetch_ctrl : PC, issue and redirect control for single-cycle imem
// Revision        : 1.0
// ---------------------------------------------------------------------------
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [15:0]           mem_data_out,
  input  logic [15:0]           mem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [15:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  halted
);

  typedef struct packed {
    logic [15:0]           instr;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t          r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [c_CNT_W-1:0]    w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_issue;
  logic                  w_pop;
  fetch_entry_t          w_push_entry;
  fetch_entry_t          w_head;
  logic                  w_unused_full;
  logic                  w_unused_rpc0;

  // rst gates issue combinationally so no read overlaps the memory image load.
  assign w_issue = (r_state == FETCH) & (w_count < c_CNT_W'(DEPTH))
                 & ~redirect_valid & ~rst;
  assign w_pop   = instr_valid & instr_ready;

  assign mem_en       = w_issue;
  assign mem_addr     = r_pc;
  assign mem_wr       = 1'b0;
  assign mem_data_out = '0;

  assign w_push_entry = '{instr: mem_rdata, pc: r_pc};
  assign instr        = w_head.instr;
  assign instr_pc     = w_head.pc;
  assign instr_valid  = ~w_empty;
  assign halted       = (r_state == HALTED);

  assign w_unused_full = w_full;
  assign w_unused_rpc0 = redirect_pc[0];

  fetch_queue #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (w_issue),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_state <= FETCH;
    end else if (redirect_valid) begin
      r_pc    <= {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
      r_state <= FETCH;
    end else if (w_issue) begin
      r_pc <= r_pc + ADDR_WIDTH'(2);
      if (is_hlt(mem_rdata)) r_state <= HALTED;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_inst_fetch_ctrl : randomized bench for inst_fetch_ctrl vs queue model
// Revision           : 1.0
// ---------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

  localparam int AW    = 16;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic          mem_wr;
  logic [15:0]   mem_data_out;
  logic [15:0]   mem_rdata;
  logic [15:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          halted;

  logic [AW-1:0] w2_mem_addr;
  logic          w2_mem_en;
  logic          w2_mem_wr;
  logic [15:0]   w2_mem_data_out;
  logic [15:0]   w2_mem_rdata;
  logic [15:0]   w2_instr;
  logic [AW-1:0] w2_instr_pc;
  logic          w2_instr_valid;
  logic          w2_halted;

  logic [15:0] tbmem [32768];

  always #5 clk = ~clk;

  assign mem_rdata    = tbmem[mem_addr[15:1]];
  assign w2_mem_rdata = tbmem[w2_mem_addr[15:1]];

  inst_fetch_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .halted(halted)
  );

  inst_fetch_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(16'hFFFC)) dut_wrap (
    .clk(clk), .rst(rst), .mem_addr(w2_mem_addr), .mem_en(w2_mem_en), .mem_wr(w2_mem_wr),
    .mem_data_out(w2_mem_data_out), .mem_rdata(w2_mem_rdata),
    .redirect_valid(1'b0), .redirect_pc(16'h0000),
    .instr(w2_instr), .instr_pc(w2_instr_pc), .instr_valid(w2_instr_valid),
    .instr_ready(1'b1), .halted(w2_halted)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of delivered {instr, pc} words plus fetch pointer.
  int          m_pc;
  bit          m_halt;
  logic [31:0] m_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = 0;
    m_halt = 0;
    m_q.delete();
  endtask

  // Called just after a falling edge with this cycle's inputs already applied.
  task automatic step();
    logic [15:0] w;
    bit          issue;
    #1;
    if (rst) begin
      check("rst_valid", instr_valid, 1'b0);
      check("rst_mem_en", mem_en, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_instr", instr, 16'h0);
      check("rst_instr_pc", instr_pc, 16'h0);
      check("rst_mem_wr", mem_wr, 1'b0);
      model_reset();
    end else begin
      issue = !m_halt && (m_q.size() < DEPTH) && !redirect_valid;
      check("valid", instr_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check("instr", instr, m_q[0][31:16]);
        check("instr_pc", instr_pc, m_q[0][15:0]);
      end
      check("halted", halted, m_halt);
      check("mem_en", mem_en, issue);
      check("mem_addr", mem_addr, m_pc);
      check("mem_wdata", {mem_wr, mem_data_out}, 17'h0);
      if (redirect_valid) begin
        m_q.delete();
        m_pc   = redirect_pc & 16'hFFFE;
        m_halt = 0;
      end else begin
        if (m_q.size() != 0 && instr_ready) void'(m_q.pop_front());
        if (issue) begin
          w = tbmem[m_pc >> 1];
          m_q.push_back({w, m_pc[15:0]});
          if (w[15:12] == 4'hF) m_halt = 1;
          m_pc = (m_pc + 2) & 16'hFFFF;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] wrap_pc [3];
    wrap_pc[0] = 16'hFFFC;
    wrap_pc[1] = 16'hFFFE;
    wrap_pc[2] = 16'h0000;

    for (int i = 0; i < 32768; i++) tbmem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    tbmem[0] = 16'h1111;
    tbmem[1] = 16'h2222;
    tbmem[2] = 16'h3333;
    tbmem[3] = 16'hF000;
    tbmem[16'h7FFE] = 16'hAAAA;
    tbmem[16'h7FFF] = 16'hBBBB;

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    model_reset();
    @(negedge clk);
    step();
    step();

    // Straight-line fetch and wrap-around on the second instance.
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        check("seq_pc", instr_pc, 16'((k - 1) * 2));
        check("wrap_valid", w2_instr_valid, 1'b1);
        check("wrap_pc", w2_instr_pc, wrap_pc[k - 1]);
      end
      step();
    end

    // Stall: queue fills, issue stops, head holds.
    rst = 1'b1;
    step();
    rst         = 1'b0;
    instr_ready = 1'b0;
    step();
    step();
    check("full_no_issue", mem_en, 1'b0);
    check("full_head", instr, 16'h1111);
    step();
    instr_ready = 1'b1;
    repeat (4) step();

    // Redirect to an odd address with a full queue.
    instr_ready = 1'b0;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0041;
    step();
    redirect_valid = 1'b0;
    check("redir_flush", instr_valid, 1'b0);
    check("redir_addr", mem_addr, 16'h0040);
    instr_ready = 1'b1;
    step();
    check("redir_first_pc", instr_pc, 16'h0040);
    step();

    // HLT at address 6, then redirect out of HALTED.
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0000;
    step();
    redirect_valid = 1'b0;
    repeat (8) step();
    check("hlt_halted", halted, 1'b1);
    check("hlt_no_issue", mem_en, 1'b0);
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("hlt_cleared", halted, 1'b0);
    check("hlt_restart", mem_addr, 16'h0000);
    step();
    step();

    // Asynchronous reset between edges.
    #3 rst = 1'b1;
    #1;
    check("async_valid", instr_valid, 1'b0);
    check("async_mem_en", mem_en, 1'b0);
    step();
    rst = 1'b0;
    step();
    check("async_restart", instr_pc, 16'h0000);

    for (int i = 4; i < 64; i++)
      if ($urandom_range(0, 9) == 0) tbmem[i] = {4'hF, 12'($urandom)};

    for (int n = 0; n < 2000; n++) begin
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 16'($urandom_range(0, 127));
      rst            = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
